// File: rtl/uop_queue_pkg.sv
// Shared micro-op definitions for the decoded-uop queue: width, field layout
// and the all-zero NOP used to blank unused output lanes.
package uop_queue_pkg;

    localparam int unsigned UOP_W = 20;

    localparam int unsigned ALU_MSB     = 19;
    localparam int unsigned ALU_LSB     = 16;
    localparam int unsigned MASK_BIT    = 15;
    localparam int unsigned LD_BIT      = 14;
    localparam int unsigned WR_BIT      = 13;
    localparam int unsigned FLAGS_BIT   = 12;
    localparam int unsigned DEST_MSB    = 11;
    localparam int unsigned DEST_LSB    = 8;
    localparam int unsigned ALU_MUX_MSB = 7;
    localparam int unsigned ALU_MUX_LSB = 6;
    localparam int unsigned B_MSB       = 5;
    localparam int unsigned B_LSB       = 3;
    localparam int unsigned A_MSB       = 2;
    localparam int unsigned A_LSB       = 0;

    typedef struct packed {
        logic [3:0] alu;
        logic       mask;
        logic       ld;
        logic       wr;
        logic       flags;
        logic [3:0] dest;
        logic [1:0] alu_mux;
        logic [2:0] b;
        logic [2:0] a;
    } uop_t;

    localparam logic [UOP_W-1:0] UOP_NOP = '0;

endpackage

// File: rtl/uop_queue_if.sv
// Decoder-to-backend bundle for uop_queue; master drives the group and the
// take count, slave is the queue itself.
interface uop_queue_if #(
    parameter int unsigned UOP_W     = uop_queue_pkg::UOP_W,
    parameter int unsigned IN_LANES  = 3,
    parameter int unsigned OUT_LANES = 2,
    parameter int unsigned DEPTH     = 8
);
    import uop_queue_pkg::*;

    localparam int unsigned IN_CNT_W  = $clog2(IN_LANES + 1);
    localparam int unsigned OUT_CNT_W = $clog2(OUT_LANES + 1);
    localparam int unsigned OCC_W     = $clog2(DEPTH + 1);

    logic                       flush;
    logic                       in_valid;
    logic [IN_CNT_W-1:0]        in_count;
    logic [IN_LANES*UOP_W-1:0]  in_uops;
    logic                       in_ready;
    logic [OUT_LANES*UOP_W-1:0] out_uops;
    logic [OUT_CNT_W-1:0]       out_count;
    logic [OUT_CNT_W-1:0]       out_take;
    logic [OCC_W-1:0]           occupancy;
    logic                       err;

    modport master (
        output flush, in_valid, in_count, in_uops, out_take,
        input  in_ready, out_uops, out_count, occupancy, err
    );

    modport slave (
        input  flush, in_valid, in_count, in_uops, out_take,
        output in_ready, out_uops, out_count, occupancy, err
    );

endinterface

// File: rtl/uop_ring.sv
// Uop storage: multi-write, multi-read register array with no reset.
module uop_ring #(
    parameter int unsigned UOP_W    = 20,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WR_PORTS = 3,
    parameter int unsigned RD_PORTS = 2,
    localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic [WR_PORTS-1:0]       we_i,
    input  logic [WR_PORTS*PTR_W-1:0] waddr_i,
    input  logic [WR_PORTS*UOP_W-1:0] wdata_i,
    input  logic [RD_PORTS*PTR_W-1:0] raddr_i,
    output logic [RD_PORTS*UOP_W-1:0] rdata_o
);

    logic [UOP_W-1:0] mem_q [DEPTH];

    // Write addresses within one group are always distinct.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < int'(WR_PORTS); k++) begin
            if (we_i[k]) begin
                mem_q[waddr_i[k*PTR_W +: PTR_W]] <= wdata_i[k*UOP_W +: UOP_W];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < int'(RD_PORTS); k++) begin
            rdata_o[k*UOP_W +: UOP_W] = mem_q[raddr_i[k*PTR_W +: PTR_W]];
        end
    end

endmodule

// File: rtl/uop_queue.sv
// Decoded-uop queue: multi-lane push from the decoder, multi-lane present/retire
// to the backend, with flush, sticky protocol-error flag and registered outputs.
module uop_queue #(
    parameter int unsigned UOP_W     = uop_queue_pkg::UOP_W,
    parameter int unsigned IN_LANES  = 3,
    parameter int unsigned OUT_LANES = 2,
    parameter int unsigned DEPTH     = 8
) (
    input  logic         clk,
    input  logic         a_rst,
    uop_queue_if.slave   bus
);
    import uop_queue_pkg::*;

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned OCC_W     = $clog2(DEPTH + 1);
    localparam int unsigned IN_CNT_W  = $clog2(IN_LANES + 1);
    localparam int unsigned OUT_CNT_W = $clog2(OUT_LANES + 1);

    localparam logic [OCC_W-1:0] DEPTH_O     = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] IN_LANES_O  = OCC_W'(IN_LANES);
    localparam logic [OCC_W-1:0] OUT_LANES_O = OCC_W'(OUT_LANES);

    logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]           occ_q, occ_d;
    logic                       err_q, err_d;
    logic                       in_ready, over_in, over_out;
    logic [IN_CNT_W-1:0]        push_sat, push_n;
    logic [OUT_CNT_W-1:0]       out_cnt, pop_n;
    logic [IN_LANES-1:0]        we;
    logic [IN_LANES*PTR_W-1:0]  waddr;
    logic [OUT_LANES*PTR_W-1:0] raddr;
    logic [OUT_LANES*UOP_W-1:0] rdata;

    always_comb begin
        // Space check uses registered occupancy only; same-cycle pops are not credited.
        in_ready = (DEPTH_O - occ_q) >= IN_LANES_O;
        out_cnt  = (occ_q >= OUT_LANES_O) ? OUT_CNT_W'(OUT_LANES) : OUT_CNT_W'(occ_q);

        over_in  = bus.in_valid && ({1'b0, bus.in_count} > (IN_CNT_W + 1)'(IN_LANES));
        push_sat = over_in ? IN_CNT_W'(IN_LANES) : bus.in_count;
        push_n   = (bus.in_valid && in_ready && !bus.flush) ? push_sat : '0;

        over_out = bus.out_take > out_cnt;
        pop_n    = over_out ? out_cnt : bus.out_take;

        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        err_d  = err_q;
        if (bus.flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            head_d = head_q + PTR_W'(pop_n);
            tail_d = tail_q + PTR_W'(push_n);
            occ_d  = occ_q + OCC_W'(push_n) - OCC_W'(pop_n);
            err_d  = err_q | over_in | over_out;
        end
    end

    always_comb begin
        we    = '0;
        waddr = '0;
        for (int k = 0; k < int'(IN_LANES); k++) begin
            we[k]                   = IN_CNT_W'(k) < push_n;
            waddr[k*PTR_W +: PTR_W] = tail_q + PTR_W'(k);
        end
        raddr = '0;
        for (int k = 0; k < int'(OUT_LANES); k++) begin
            raddr[k*PTR_W +: PTR_W] = head_q + PTR_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (!a_rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            err_q  <= err_d;
        end
    end

    uop_ring #(
        .UOP_W    (UOP_W),
        .DEPTH    (DEPTH),
        .WR_PORTS (IN_LANES),
        .RD_PORTS (OUT_LANES)
    ) u_ring (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (bus.in_uops),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_count = out_cnt;
        bus.occupancy = occ_q;
        bus.err       = err_q;
        bus.out_uops  = '0;
        for (int k = 0; k < int'(OUT_LANES); k++) begin
            bus.out_uops[k*UOP_W +: UOP_W] =
                (OUT_CNT_W'(k) < out_cnt) ? rdata[k*UOP_W +: UOP_W] : UOP_NOP;
        end
    end

endmodule

// File: doc/uop_queue.md
UOP_QUEUE -- requirements
Module: uop_queue

Interface
REQ-001 Parameter UOP_W, default 20, SHALL set the micro-op width in bits.
REQ-002 Parameter IN_LANES, default 3, SHALL set the max uops written per cycle.
REQ-003 Parameter OUT_LANES, default 2, SHALL set the max uops presented/retired per cycle.
REQ-004 Parameter DEPTH, default 8, SHALL set entries; power of two, >= IN_LANES+OUT_LANES.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 a_rst  in  1  reset, synchronous, active-low.
REQ-007 flush  in  1  discard all queued uops (branch taken / pc invalidate).
REQ-008 in_valid  in  1  decoder offers a uop group.
REQ-009 in_count  in  clog2(IN_LANES+1)  valid uops in group, 0..IN_LANES, lane 0 oldest.
REQ-010 in_uops  in  IN_LANES*UOP_W  group; lane k at bits [k*UOP_W +: UOP_W].
REQ-011 in_ready  out  1  queue can accept a full group this cycle.
REQ-012 out_uops  out  OUT_LANES*UOP_W  oldest entries; lane 0 = head.
REQ-013 out_count  out  clog2(OUT_LANES+1)  valid out lanes = min(occupancy, OUT_LANES).
REQ-014 out_take  in  clog2(OUT_LANES+1)  uops consumed by backend this cycle.
REQ-015 occupancy  out  clog2(DEPTH+1)  entries held.
REQ-016 err  out  1  sticky protocol-error flag.

Function
REQ-017 in_ready SHALL be 1 iff DEPTH - occupancy >= IN_LANES, computed from registered occupancy only (pops of the same cycle not credited).
REQ-018 Push SHALL occur when in_valid && in_ready && !flush: lanes 0..in_count-1 written at tail, tail += in_count mod DEPTH.
REQ-019 in_valid with in_count = 0 SHALL be a no-op.
REQ-020 in_count > IN_LANES SHALL be treated as IN_LANES and set err.
REQ-021 Pop SHALL remove min(out_take, out_count) entries at head; head += that amount mod DEPTH.
REQ-022 out_take > out_count SHALL set err; no underflow of occupancy.
REQ-023 Simultaneous push and pop SHALL both apply; occupancy_next = occupancy + pushed - popped.
REQ-024 Pointers SHALL wrap modulo DEPTH; groups straddling the wrap point SHALL keep program order.
REQ-025 A uop pushed in cycle N SHALL be visible on out_uops in cycle N+1 (one-cycle latency, no bypass).
REQ-026 out_uops/out_count SHALL depend only on registered state (no combinational path from any input).
REQ-027 Out lanes at index >= out_count SHALL drive all zeros.
REQ-028 flush SHALL dominate: head, tail, occupancy cleared next cycle; same-cycle push and pop ignored; err unchanged.
REQ-029 err SHALL remain 1 until reset.

Reset
REQ-030 a_rst low at a rising edge SHALL clear head, tail, occupancy, err; outputs next cycle: in_ready=1, out_count=0, out_uops=0, occupancy=0, err=0.
REQ-031 Reset mid-operation SHALL discard all entries, overriding flush, push, pop; storage contents need not be cleared.

Structure
REQ-032 Shared package SHALL hold UOP_W, uop field positions (ALU 19:16, MASK 15, LD 14, WR 13, FLAGS 12, DEST 11:8, ALU_MUX 7:6, B 5:3, A 2:0) and a UOP_NOP all-zero constant.
REQ-033 Storage SHALL be sub-module uop_ring: DEPTH x UOP_W array, IN_LANES write ports, OUT_LANES read ports, no reset.
REQ-034 Pointer/occupancy control SHALL reside in uop_queue.

Verification (defaults)
REQ-035 Reset then push in_count=3 {A,B,C} -> next cycle out_count=2, out_uops={B,A} lanes 1,0, occupancy=3, in_ready=1.
REQ-036 Push 3 per cycle, out_take=0, three cycles -> occupancy 3,6; in_ready=0 at 6; third push ignored, occupancy stays 6.
REQ-037 Occupancy 6, push 3 with out_take=2 same cycle -> rejected (in_ready=0), occupancy=4; next cycle push accepted -> 7.
REQ-038 Head at 6, push 3 -> entries at 6,7,0; popped in order over two cycles, out_count 2 then 1.
REQ-039 Occupancy 5 with push and out_take=2 plus flush -> occupancy 0, out_count 0, out_uops 0, err 0.
REQ-040 occupancy=1, out_take=2 -> occupancy 0, err 1; err held through flush, cleared only by a_rst low.
